// File: rtl/mem_wb_stage.sv
// MEM-stage result select and forwarding sources, MEM:WB pipeline register
// driving the register-file write port, retire counter and drain handshake.
module mem_wb_stage #(
    parameter int DSIZE = 16,
    parameter int RSIZE = 4,
    parameter int CSIZE = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Mem_Valid,
    input  logic [DSIZE-1:0] Mem_ALUResult,
    input  logic [DSIZE-1:0] Mem_PCplus1,
    input  logic [DSIZE-1:0] Mem_ReadData,
    input  logic [RSIZE-1:0] Mem_RDest_rd,
    input  logic             Mem_Mem2Reg,
    input  logic             Mem_RFileWrite,
    input  logic             Mem_Sel_ALU_PC1,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             Drain_req,
    output logic [DSIZE-1:0] Mem_Result,
    output logic [RSIZE-1:0] Mem_RF_Dest,
    output logic             Mem_RFWrite_Eb,
    output logic [DSIZE-1:0] WBResult,
    output logic [RSIZE-1:0] WB_RF_Dest,
    output logic             WB_RFWrite_Eb,
    output logic [CSIZE-1:0] Retire_cnt,
    output logic             Drain_ack
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

    drain_state_t state, state_next;
    logic [1:0]   idle_cnt, idle_next, idle_step;
    logic         retire;

    // MEM stage: link address wins over load data, which wins over ALU result
    always_comb begin
        if (Mem_Sel_ALU_PC1) begin
            Mem_Result = Mem_PCplus1;
        end else if (Mem_Mem2Reg) begin
            Mem_Result = Mem_ReadData;
        end else begin
            Mem_Result = Mem_ALUResult;
        end
    end

    assign Mem_RF_Dest    = Mem_RDest_rd;
    assign Mem_RFWrite_Eb = Mem_Valid & Mem_RFileWrite & (Mem_RDest_rd != '0);

    // MEM:WB register boundary
    always_ff @(posedge Clk) begin
        if (!Rst || Flush) begin
            WBResult      <= '0;
            WB_RF_Dest    <= '0;
            WB_RFWrite_Eb <= 1'b0;
        end else if (!Stall) begin
            WBResult      <= Mem_Result;
            WB_RF_Dest    <= Mem_RDest_rd;
            WB_RFWrite_Eb <= Mem_RFWrite_Eb;
        end
    end

    assign retire = Mem_Valid & ~Stall & ~Flush;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            Retire_cnt <= '0;
        end else if (retire && (Retire_cnt != '1)) begin
            Retire_cnt <= Retire_cnt + CSIZE'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state    <= RUN;
            idle_cnt <= 2'd0;
        end else begin
            state    <= state_next;
            idle_cnt <= idle_next;
        end
    end

    assign idle_step = Mem_Valid ? 2'd0 : ((idle_cnt == 2'd2) ? 2'd2 : idle_cnt + 2'd1);

    // Leaving DRAIN needs two idle edges and no write still parked in WB
    always_comb begin
        state_next = state;
        idle_next  = idle_cnt;
        case (state)
            RUN: begin
                idle_next = 2'd0;
                if (Drain_req) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!Drain_req) begin
                    state_next = RUN;
                    idle_next  = 2'd0;
                end else begin
                    idle_next = idle_step;
                    if ((idle_step == 2'd2) && !WB_RFWrite_Eb) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                idle_next = 2'd0;
                if (!Drain_req) begin
                    state_next = RUN;
                end else if (Mem_Valid) begin
                    state_next = DRAIN;
                end
            end
            default: begin
                state_next = RUN;
                idle_next  = 2'd0;
            end
        endcase
    end

    assign Drain_ack = (state == DONE);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboarded bench for mem_wb_stage: a cycle-level reference model pushes
// expected outputs, an independent monitor pops and compares them.
module tb_mem_wb_stage;
    localparam int DS = 16;
    localparam int RS = 4;
    localparam int CS = 4;
    localparam int CMAX = (1 << CS) - 1;

    typedef struct {
        logic [DS-1:0] mres;
        logic [RS-1:0] mdst;
        logic          meb;
        logic [DS-1:0] wres;
        logic [RS-1:0] wdst;
        logic          web;
        logic [CS-1:0] cnt;
        logic          ack;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, valid, m2r, rfw, sel, stall, flush, dreq;
    logic [DS-1:0] alu, pc1, rdata;
    logic [RS-1:0] rd;
    logic [DS-1:0] mem_result, wb_result;
    logic [RS-1:0] mem_dest, wb_dest;
    logic          mem_eb, wb_eb, drain_ack;
    logic [CS-1:0] retire_cnt;

    mem_wb_stage #(.DSIZE(DS), .RSIZE(RS), .CSIZE(CS)) dut (
        .Clk(clk), .Rst(rst), .Mem_Valid(valid),
        .Mem_ALUResult(alu), .Mem_PCplus1(pc1), .Mem_ReadData(rdata),
        .Mem_RDest_rd(rd), .Mem_Mem2Reg(m2r), .Mem_RFileWrite(rfw),
        .Mem_Sel_ALU_PC1(sel), .Stall(stall), .Flush(flush), .Drain_req(dreq),
        .Mem_Result(mem_result), .Mem_RF_Dest(mem_dest), .Mem_RFWrite_Eb(mem_eb),
        .WBResult(wb_result), .WB_RF_Dest(wb_dest), .WB_RFWrite_Eb(wb_eb),
        .Retire_cnt(retire_cnt), .Drain_ack(drain_ack)
    );

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Reference model state: what the registered outputs hold right now
    logic [DS-1:0] m_wres;
    logic [RS-1:0] m_wdst;
    logic          m_web;
    int            m_cnt;
    int            m_mode;      // 0 running, 1 draining, 2 drained
    int            m_idle;      // idle edges seen since draining began

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    // Record the expectation for this cycle, then advance the model by one edge
    task automatic tick();
        exp_t e;
        e.mres = sel ? pc1 : (m2r ? rdata : alu);
        e.mdst = rd;
        e.meb  = valid && rfw && (rd != 0);
        e.wres = m_wres;
        e.wdst = m_wdst;
        e.web  = m_web;
        e.cnt  = CS'(m_cnt);
        e.ack  = (m_mode == 2);
        q.push_back(e);

        if (!rst) begin
            m_wres = '0; m_wdst = '0; m_web = 1'b0;
            m_cnt = 0; m_mode = 0; m_idle = 0;
        end else begin
            if (m_mode == 0) begin
                if (dreq) begin m_mode = 1; m_idle = 0; end
            end else if (m_mode == 1) begin
                if (!dreq) m_mode = 0;
                else begin
                    m_idle = valid ? 0 : m_idle + 1;
                    if (m_idle >= 2 && !m_web) m_mode = 2;
                end
            end else begin
                if (!dreq) m_mode = 0;
                else if (valid) begin m_mode = 1; m_idle = 0; end
            end
            if (valid && !stall && !flush && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (flush) begin
                m_wres = '0; m_wdst = '0; m_web = 1'b0;
            end else if (!stall) begin
                m_wres = e.mres; m_wdst = rd; m_web = e.meb;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input logic v, input logic [DS-1:0] a, input logic [DS-1:0] p,
                          input logic [DS-1:0] r, input logic [RS-1:0] d,
                          input logic mr, input logic w, input logic s);
        valid = v; alu = a; pc1 = p; rdata = r; rd = d; m2r = mr; rfw = w; sel = s;
    endtask

    task automatic rand_cycle(input int pv, input int ps, input int pf, input int pr, input int pd);
        set_op(($urandom_range(99) < pv), DS'($urandom), DS'($urandom), DS'($urandom),
               RS'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        stall = ($urandom_range(99) < ps);
        flush = ($urandom_range(99) < pf);
        rst   = !($urandom_range(99) < pr);
        if ($urandom_range(99) < pd) dreq = ~dreq;
        tick();
    endtask

    // Monitor: compare every DUT output against the queued expectation
    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                me = q.pop_front();
                chk("mem_result", 32'(mem_result), 32'(me.mres));
                chk("mem_dest",   32'(mem_dest),   32'(me.mdst));
                chk("mem_eb",     32'(mem_eb),     32'(me.meb));
                chk("wb_result",  32'(wb_result),  32'(me.wres));
                chk("wb_dest",    32'(wb_dest),    32'(me.wdst));
                chk("wb_eb",      32'(wb_eb),      32'(me.web));
                chk("retire_cnt", 32'(retire_cnt), 32'(me.cnt));
                chk("drain_ack",  32'(drain_ack),  32'(me.ack));
            end
        end
    end

    initial begin
        m_wres = '0; m_wdst = '0; m_web = 1'b0;
        m_cnt = 0; m_mode = 0; m_idle = 0;
        rst = 1'b0; stall = 1'b0; flush = 1'b0; dreq = 1'b0;
        set_op(1'b1, 16'h1111, 16'h2222, 16'h3333, 4'd7, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        tick();
        rst = 1'b1;

        // Result mux, then R0 suppression
        set_op(1'b1, 16'h1234, 16'h0040, 16'hBEEF, 4'd3, 1'b0, 1'b1, 1'b0); tick();
        set_op(1'b1, 16'h1234, 16'h0040, 16'hBEEF, 4'd3, 1'b1, 1'b1, 1'b0); tick();
        set_op(1'b1, 16'h1234, 16'h0040, 16'hBEEF, 4'd3, 1'b1, 1'b1, 1'b1); tick();
        set_op(1'b1, 16'h5555, 16'h0040, 16'hBEEF, 4'd0, 1'b0, 1'b1, 1'b0); tick();
        set_op(1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0); tick();

        // Stall holds WB; stall with flush bubbles it
        set_op(1'b1, 16'h00AA, 16'h0000, 16'h0000, 4'd5, 1'b0, 1'b1, 1'b0); tick();
        set_op(1'b1, 16'h00BB, 16'h0000, 16'h0000, 4'd6, 1'b0, 1'b1, 1'b0);
        stall = 1'b1;
        repeat (3) tick();
        flush = 1'b1; tick();
        stall = 1'b0; flush = 1'b0; valid = 1'b0; tick();

        // Counter saturation
        rst = 1'b0; tick(); rst = 1'b1;
        for (int i = 0; i < CMAX + 5; i++) begin
            set_op(1'b1, DS'(i), 16'h0, 16'h0, RS'(i), 1'b0, 1'b1, 1'b0);
            tick();
        end

        // Drain handshake from an empty pipe
        rst = 1'b0; tick(); rst = 1'b1;
        set_op(1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        dreq = 1'b1;
        repeat (5) tick();
        valid = 1'b1; tick();
        valid = 1'b0;
        repeat (4) tick();
        dreq = 1'b0;
        repeat (2) tick();

        // Reset while draining with a write parked in WB
        dreq = 1'b1;
        set_op(1'b1, 16'hCAFE, 16'h0, 16'h0, 4'd9, 1'b0, 1'b1, 1'b0); tick();
        valid = 1'b0; stall = 1'b1;
        repeat (3) tick();
        rst = 1'b0; tick();
        rst = 1'b1; stall = 1'b0;
        repeat (4) tick();
        dreq = 1'b0; tick();

        // Randomized traffic: busy, then sparse so drains complete
        for (int i = 0; i < 400; i++) rand_cycle(70, 15, 8, 2, 10);
        for (int i = 0; i < 400; i++) rand_cycle(15, 10, 5, 1, 6);

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
